// File: rtl/pulse_averager.sv
// pulse_averager: coherently sums ADC samples that share the same in-pulse
// index over n_avg consecutive pulses. Sums live in an internal accumulator
// RAM updated by a fixed 3-stage read-modify-write pipeline with forwarding;
// a separate read port returns accumulator words for readout glue.
//
// Stream/handshake semantics: the pulse stream has no backpressure. A sample
// is offered on every rising edge where pulse_valid=1 and is either taken or
// silently dropped (no ready). rd_en is a single-cycle request; rd_data
// carries the addressed word from the following edge and holds it until the
// next request.
module pulse_averager #(
  parameter int DATA_WIDTH = 14,
  parameter int CNT_WIDTH  = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int ACC_WIDTH  = 32,
  parameter int NAVG_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic                  pulse_valid,
  input  logic [CNT_WIDTH-1:0]  pulse_cnt,
  input  logic                  pulse_start,
  input  logic [NAVG_WIDTH-1:0] n_avg,
  input  logic                  restart,
  output logic                  busy,
  output logic                  done,
  output logic [NAVG_WIDTH-1:0] pulse_count,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ACC_WIDTH-1:0]  rd_data,
  output logic [1:0]            state_dbg
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_ACCUM = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Run control
  logic [1:0]            state_q, state_d;
  logic [NAVG_WIDTH-1:0] navg_q, navg_d;
  logic [NAVG_WIDTH-1:0] count_q, count_d;
  logic                  first_q, first_d;

  logic                  in_range;
  logic                  last_pulse;
  logic                  take;
  logic                  samp_first;
  logic                  accept;
  logic [ACC_WIDTH-1:0]  adc_sext;

  // Pipeline stage registers
  logic                  s0_valid_q, s1_valid_q, s2_valid_q;
  logic [ADDR_WIDTH-1:0] s0_addr_q, s1_addr_q, s2_addr_q;
  logic [ACC_WIDTH-1:0]  s0_data_q, s1_data_q, s2_data_q;
  logic                  s0_first_q, s1_first_q, s2_first_q;
  logic [ACC_WIDTH-1:0]  s1_rd_q;
  logic [ACC_WIDTH-1:0]  s2_base_q;

  logic [ACC_WIDTH-1:0]  wr_val;
  logic [ACC_WIDTH-1:0]  rd_fwd;
  logic [ACC_WIDTH-1:0]  base_fwd;

  logic [ACC_WIDTH-1:0]  mem_q [DEPTH];

  assign in_range   = ~|pulse_cnt[CNT_WIDTH-1:ADDR_WIDTH];
  assign last_pulse = (count_q + NAVG_WIDTH'(1)) == navg_q;
  assign adc_sext   = {{(ACC_WIDTH-DATA_WIDTH){adc_data[DATA_WIDTH-1]}}, adc_data};

  // Next-state logic: restart wins over everything and re-arms the run.
  always_comb begin
    state_d    = state_q;
    navg_d     = navg_q;
    count_d    = count_q;
    first_d    = first_q;
    take       = 1'b0;
    samp_first = first_q;
    if (restart) begin
      state_d = ST_ARM;
      navg_d  = (n_avg == '0) ? NAVG_WIDTH'(1) : n_avg;
      count_d = '0;
      first_d = 1'b1;
    end else begin
      case (state_q)
        ST_ARM: begin
          if (pulse_start) begin
            state_d    = ST_ACCUM;
            count_d    = '0;
            first_d    = 1'b1;
            take       = 1'b1;
            samp_first = 1'b1;
          end
        end
        ST_ACCUM: begin
          if (pulse_start) begin
            if (last_pulse) begin
              // The start that ends the run carries no sample for this run.
              state_d = ST_DONE;
            end else begin
              count_d    = count_q + NAVG_WIDTH'(1);
              first_d    = 1'b0;
              take       = 1'b1;
              samp_first = 1'b0;
            end
          end else begin
            take = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign accept = take & pulse_valid & in_range;

  // Run control registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      navg_q  <= NAVG_WIDTH'(1);
      count_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      navg_q  <= navg_d;
      count_q <= count_d;
      first_q <= first_d;
    end
  end

  // Pipeline valid bits; a restart squashes everything in flight.
  always_ff @(posedge clk) begin
    if (!resetn || restart) begin
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s0_valid_q <= accept;
      s1_valid_q <= s0_valid_q;
      s2_valid_q <= s1_valid_q;
    end
  end

  // Value about to be written by S2; the first pulse of a run overwrites.
  assign wr_val   = s2_first_q ? s2_data_q : (s2_base_q + s2_data_q);
  // A write landing on the same edge as the S1 read is not yet in the RAM.
  assign rd_fwd   = (s2_valid_q && (s2_addr_q == s0_addr_q)) ? wr_val : mem_q[s0_addr_q];
  // The previous sample may target the same word; take its fresh sum.
  assign base_fwd = (s2_valid_q && (s2_addr_q == s1_addr_q)) ? wr_val : s1_rd_q;

  // Pipeline payload: S0 capture, S1 RAM read, S2 operand select.
  always_ff @(posedge clk) begin
    s0_addr_q  <= pulse_cnt[ADDR_WIDTH-1:0];
    s0_data_q  <= adc_sext;
    s0_first_q <= samp_first;
    s1_addr_q  <= s0_addr_q;
    s1_data_q  <= s0_data_q;
    s1_first_q <= s0_first_q;
    s1_rd_q    <= rd_fwd;
    s2_addr_q  <= s1_addr_q;
    s2_data_q  <= s1_data_q;
    s2_first_q <= s1_first_q;
    s2_base_q  <= base_fwd;
  end

  // Accumulator write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (s2_valid_q) begin
      mem_q[s2_addr_q] <= wr_val;
    end
  end

  // Readout port, independent of the run state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem_q[rd_addr];
    end
  end

  assign busy        = (state_q == ST_ARM) || (state_q == ST_ACCUM);
  assign done        = (state_q == ST_DONE);
  assign pulse_count = count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pulse_averager.sv
// Bench for pulse_averager: a behavioural pulse generator drives randomized
// ADC pulses; completed runs are folded into a per-index expected-sum array
// and compared against RAM readback of a 32-bit and a 16-bit accumulator DUT.
`timescale 1ns/1ps
module tb_pulse_averager;
  localparam int DW = 14;
  localparam int CW = 16;
  localparam int AW = 10;
  localparam int NW = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          pulse_valid = 1'b0;
  logic [CW-1:0] pulse_cnt = '0;
  logic          pulse_start = 1'b0;
  logic [NW-1:0] n_avg = '0;
  logic          restart = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;

  logic          busy, done, busy16, done16;
  logic [NW-1:0] pulse_count, pulse_count16;
  logic [31:0]   rd_data;
  logic [15:0]   rd_data16;
  logic [1:0]    state_dbg, state_dbg16;

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  pulse_averager #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .ADDR_WIDTH(AW), .ACC_WIDTH(32), .NAVG_WIDTH(NW)) u_dut (
    .clk(clk), .resetn(resetn), .adc_data(adc_data), .pulse_valid(pulse_valid),
    .pulse_cnt(pulse_cnt), .pulse_start(pulse_start), .n_avg(n_avg), .restart(restart),
    .busy(busy), .done(done), .pulse_count(pulse_count), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .state_dbg(state_dbg)
  );

  pulse_averager #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .ADDR_WIDTH(AW), .ACC_WIDTH(16), .NAVG_WIDTH(NW)) u_dut16 (
    .clk(clk), .resetn(resetn), .adc_data(adc_data), .pulse_valid(pulse_valid),
    .pulse_cnt(pulse_cnt), .pulse_start(pulse_start), .n_avg(n_avg), .restart(restart),
    .busy(busy16), .done(done16), .pulse_count(pulse_count16), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data16), .state_dbg(state_dbg16)
  );

  // Scoreboard state
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int gen_c = 0;
  int run_pulse = -1;
  int n_eff = 1;
  int term_cyc = -1;
  int done_rise = -1;
  int ramp = 1;
  bit armed = 1'b0;

  typedef struct {int pulse; int cnt; int val;} rec_t;
  rec_t        rec_q[$];
  logic [31:0] exp_mem [DEPTH];
  bit          known [DEPTH];

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (done === 1'b1 && done_rise < 0) done_rise = cyc;
  endtask

  task automatic invalidate();
    foreach (rec_q[i]) if (rec_q[i].cnt < DEPTH) known[rec_q[i].cnt] = 1'b0;
    rec_q.delete();
  endtask

  task automatic do_restart(input int nv);
    invalidate();
    n_avg       = NW'(nv);
    restart     = 1'b1;
    pulse_valid = 1'b0;
    pulse_start = 1'b0;
    armed       = 1'b1;
    run_pulse   = -1;
    n_eff       = (nv == 0) ? 1 : nv;
    term_cyc    = -1;
    done_rise   = -1;
    tick();
    restart = 1'b0;
  endtask

  // mode 0: constant cval, 1: random, 2: ramp
  task automatic gen_cycle(input int period, input int width, input int mode, input int cval);
    logic signed [DW-1:0] s;
    rec_t r;
    case (mode)
      0: s = DW'(cval);
      1: s = DW'($urandom_range(0, (1 << DW) - 1));
      default: begin s = DW'(ramp); ramp++; end
    endcase
    pulse_cnt   = CW'(gen_c);
    pulse_start = (gen_c == 0);
    pulse_valid = (gen_c < width);
    adc_data    = s;
    if (armed && gen_c == 0) begin
      run_pulse++;
      if (run_pulse == n_eff && term_cyc < 0) term_cyc = cyc + 1;
    end
    if (armed && pulse_valid && run_pulse >= 0 && run_pulse < n_eff) begin
      r.pulse = run_pulse;
      r.cnt   = gen_c;
      r.val   = int'(s);
      rec_q.push_back(r);
    end
    tick();
    gen_c = (gen_c + 1) % period;
  endtask

  task automatic run_pulses(input int period, input int width, input int mode, input int cval, input int np);
    for (int i = 0; i < np * period; i++) gen_cycle(period, width, mode, cval);
  endtask

  task automatic idle(input int n);
    pulse_valid = 1'b0;
    pulse_start = 1'b0;
    repeat (n) tick();
    gen_c = 0;
  endtask

  // Reference model: pulse 0 of a run sets each index, later pulses add.
  task automatic apply_model();
    for (int p = 0; p < n_eff; p++) begin
      foreach (rec_q[i]) begin
        if (rec_q[i].pulse == p && rec_q[i].cnt < DEPTH) begin
          if (p == 0) begin
            exp_mem[rec_q[i].cnt] = 32'(rec_q[i].val);
            known[rec_q[i].cnt]   = 1'b1;
          end else begin
            exp_mem[rec_q[i].cnt] = exp_mem[rec_q[i].cnt] + 32'(rec_q[i].val);
          end
        end
      end
    end
    rec_q.delete();
  endtask

  task automatic read_word(input int a, output logic [31:0] v, output logic [15:0] w);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    tick();
    v     = rd_data;
    w     = rd_data16;
    rd_en = 1'b0;
  endtask

  // Tests
  task automatic test_power_on();
    resetn = 1'b0;
    repeat (3) tick();
    n_checks++; if (busy !== 1'b0 || busy16 !== 1'b0) $display("FAIL por_busy: got %b/%b want 0", busy, busy16); else n_pass++;
    n_checks++; if (done !== 1'b0 || done16 !== 1'b0) $display("FAIL por_done: got %b/%b want 0", done, done16); else n_pass++;
    n_checks++; if (pulse_count !== '0 || pulse_count16 !== '0) $display("FAIL por_count: got %0d/%0d want 0", pulse_count, pulse_count16); else n_pass++;
    n_checks++; if (rd_data !== '0 || rd_data16 !== '0) $display("FAIL por_rd_data: got %h/%h want 0", rd_data, rd_data16); else n_pass++;
    resetn = 1'b1;
    run_pulses(4, 4, 1, 0, 2);
    idle(2);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL por_idle: busy %b done %b want 0 0 without restart", busy, done); else n_pass++;
  endtask

  task automatic test_basic();
    logic [31:0] v; logic [15:0] w;
    do_restart(1);
    run_pulses(8, 8, 1, 0, 2);
    idle(4);
    apply_model();
    do_restart(3);
    run_pulses(8, 4, 0, 100, 4);
    n_checks++; if (done_rise != term_cyc) $display("FAIL basic_done_time: rose at %0d want %0d (state %0d)", done_rise, term_cyc, state_dbg); else n_pass++;
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL basic_flags: done %b busy %b want 1 0", done, busy); else n_pass++;
    n_checks++; if (pulse_count !== NW'(2)) $display("FAIL basic_count: got %0d want 2", pulse_count); else n_pass++;
    idle(4);
    apply_model();
    for (int a = 0; a < 8; a++) begin
      read_word(a, v, w);
      if (a < 4) begin
        n_checks++; if (v !== 32'd300) $display("FAIL basic_sum[%0d]: got %0d want 300", a, v); else n_pass++;
      end else begin
        n_checks++; if (v !== exp_mem[a]) $display("FAIL basic_untouched[%0d]: got %h want %h", a, v, exp_mem[a]); else n_pass++;
      end
      n_checks++; if (w !== exp_mem[a][15:0]) $display("FAIL basic_acc16[%0d]: got %h want %h", a, w, exp_mem[a][15:0]); else n_pass++;
    end
    read_word(2, v, w);
    rd_addr = AW'(5);
    tick();
    n_checks++; if (rd_data !== exp_mem[2]) $display("FAIL rd_hold: got %h want %h", rd_data, exp_mem[2]); else n_pass++;
  endtask

  task automatic test_first_overwrite();
    logic [31:0] v; logic [15:0] w;
    do_restart(2);
    run_pulses(8, 4, 0, -5, 3);
    n_checks++; if (done_rise != term_cyc) $display("FAIL ovw_done_time: rose at %0d want %0d", done_rise, term_cyc); else n_pass++;
    idle(4);
    apply_model();
    for (int a = 0; a < 4; a++) begin
      read_word(a, v, w);
      n_checks++; if (v !== 32'hFFFF_FFF6) $display("FAIL ovw_sum[%0d]: got %h want fffffff6", a, v); else n_pass++;
      n_checks++; if (w !== 16'hFFF6) $display("FAIL ovw_acc16[%0d]: got %h want fff6", a, w); else n_pass++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v; logic [15:0] w;
    read_word(0, v, w);
    do_restart(5);
    run_pulses(8, 4, 1, 0, 2);
    gen_cycle(8, 4, 1, 0);
    gen_cycle(8, 4, 1, 0);
    resetn = 1'b0;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rst_flags: busy %b done %b want 0 0", busy, done); else n_pass++;
    n_checks++; if (pulse_count !== '0) $display("FAIL rst_count: got %0d want 0", pulse_count); else n_pass++;
    n_checks++; if (rd_data !== '0) $display("FAIL rst_rd_data: got %h want 0 (was %h)", rd_data, v); else n_pass++;
    resetn = 1'b1;
    invalidate();
    armed = 1'b0;
    idle(1);
    run_pulses(8, 4, 1, 0, 2);
    n_checks++; if (busy !== 1'b0 || pulse_count !== '0) $display("FAIL rst_needs_restart: busy %b count %0d want 0 0", busy, pulse_count); else n_pass++;
    idle(2);
  endtask

  task automatic test_forwarding();
    logic [31:0] v; logic [15:0] w;
    int n;
    do_restart(4);
    ramp = 1;
    run_pulses(1, 1, 2, 0, 5);
    n_checks++; if (done_rise != term_cyc) $display("FAIL fwd_done_time: rose at %0d want %0d", done_rise, term_cyc); else n_pass++;
    n_checks++; if (pulse_count !== NW'(3)) $display("FAIL fwd_count: got %0d want 3", pulse_count); else n_pass++;
    idle(4);
    apply_model();
    read_word(0, v, w);
    n_checks++; if (v !== 32'd10) $display("FAIL fwd_ramp_sum: got %0d want 10", v); else n_pass++;
    for (int per = 1; per <= 3; per++) begin
      n = $urandom_range(3, 6);
      do_restart(n);
      run_pulses(per, per, 1, 0, n + 1);
      idle(4);
      apply_model();
      for (int a = 0; a < per; a++) begin
        read_word(a, v, w);
        n_checks++; if (v !== exp_mem[a]) $display("FAIL fwd_p%0d[%0d]: got %h want %h", per, a, v, exp_mem[a]); else n_pass++;
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] v; logic [15:0] w;
    do_restart(4);
    run_pulses(6, 5, 1, 0, 2);
    repeat (3) gen_cycle(6, 5, 1, 0);
    do_restart(1);
    repeat (3) gen_cycle(6, 5, 1, 0);
    run_pulses(6, 5, 1, 0, 2);
    n_checks++; if (done_rise != term_cyc) $display("FAIL abort_done_time: rose at %0d want %0d", done_rise, term_cyc); else n_pass++;
    n_checks++; if (pulse_count !== '0 || done !== 1'b1) $display("FAIL abort_state: count %0d done %b want 0 1", pulse_count, done); else n_pass++;
    idle(4);
    apply_model();
    for (int a = 0; a < 5; a++) begin
      read_word(a, v, w);
      n_checks++; if (v !== exp_mem[a]) $display("FAIL abort_sum[%0d]: got %h want %h", a, v, exp_mem[a]); else n_pass++;
    end
  endtask

  task automatic test_navg_zero();
    logic [31:0] v; logic [15:0] w;
    do_restart(0);
    run_pulses(4, 4, 1, 0, 2);
    n_checks++; if (done_rise != term_cyc) $display("FAIL navg0_done_time: rose at %0d want %0d", done_rise, term_cyc); else n_pass++;
    n_checks++; if (pulse_count !== '0) $display("FAIL navg0_count: got %0d want 0", pulse_count); else n_pass++;
    idle(4);
    apply_model();
    for (int a = 0; a < 4; a++) begin
      read_word(a, v, w);
      n_checks++; if (v !== exp_mem[a]) $display("FAIL navg0_sum[%0d]: got %h want %h", a, v, exp_mem[a]); else n_pass++;
    end
  endtask

  task automatic test_cnt_range();
    logic [31:0] v; logic [15:0] w;
    do_restart(1);
    run_pulses(2010, 2000, 1, 0, 2);
    idle(4);
    apply_model();
    for (int a = 0; a < DEPTH; a++) begin
      read_word(a, v, w);
      n_checks++; if (v !== exp_mem[a]) $display("FAIL range_sum[%0d]: got %h want %h", a, v, exp_mem[a]); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] v; logic [15:0] w;
    do_restart(9);
    run_pulses(2, 1, 0, 8191, 10);
    n_checks++; if (pulse_count !== NW'(8) || done !== 1'b1) $display("FAIL wrap_state: count %0d done %b want 8 1", pulse_count, done); else n_pass++;
    idle(4);
    apply_model();
    read_word(0, v, w);
    n_checks++; if (w !== 16'd8183) $display("FAIL wrap_acc16: got %0d want 8183 (state %0d)", w, state_dbg16); else n_pass++;
    n_checks++; if (v !== 32'd73719) $display("FAIL wrap_acc32: got %0d want 73719", v); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] v; logic [15:0] w;
    int n, per, wid;
    for (int it = 0; it < 4; it++) begin
      n   = $urandom_range(1, 5);
      per = $urandom_range(3, 12);
      wid = $urandom_range(1, per);
      do_restart(n);
      n_avg = NW'($urandom_range(0, 65535));
      run_pulses(per, wid, 1, 0, n + 1);
      n_checks++; if (done_rise != term_cyc) $display("FAIL rnd%0d_done_time: rose at %0d want %0d", it, done_rise, term_cyc); else n_pass++;
      n_checks++; if (pulse_count !== NW'(n - 1) || busy !== 1'b0) $display("FAIL rnd%0d_state: count %0d busy %b want %0d 0", it, pulse_count, busy, n - 1); else n_pass++;
      idle(4);
      apply_model();
      for (int a = 0; a < wid; a++) begin
        read_word(a, v, w);
        n_checks++; if (v !== exp_mem[a]) $display("FAIL rnd%0d_sum[%0d]: got %h want %h", it, a, v, exp_mem[a]); else n_pass++;
        n_checks++; if (w !== exp_mem[a][15:0]) $display("FAIL rnd%0d_acc16[%0d]: got %h want %h", it, a, w, exp_mem[a][15:0]); else n_pass++;
      end
    end
  endtask

  // Sequence and final report
  initial begin
    test_power_on();
    test_basic();
    test_first_overwrite();
    test_reset();
    test_forwarding();
    test_abort();
    test_navg_zero();
    test_cnt_range();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
